mask_index_encoder: RTL and testbench

//  Sequential sparse-mask encoder: accepts a WIDTH-bit bitmask and emits the index of every set bit, one per cycle.

---
 rtl/mask_index_encoder_pkg.sv | 14 +
 rtl/mask_index_encoder_if.sv | 27 ++
 rtl/mask_index_encoder_prio_enc_msb.sv | 25 ++
 rtl/mask_index_encoder.sv | 78 +++++++
 tb/tb_mask_index_encoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_index_encoder_pkg.sv
// Shared constants and helpers for the sparse-mask index encoder.
// Index numbering is MSB-first: index i corresponds to mask bit (WIDTH-1-i).
package mask_index_encoder_pkg;

    localparam int MASK_W = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mask_index_encoder_if.sv
// Mask-in / index-out valid-ready bundle; master drives masks and accepts indices,
// slave is the encoder.
interface mask_index_encoder_if #(
    parameter int WIDTH = mask_index_encoder_pkg::MASK_W
);
    localparam int IDX_W = mask_index_encoder_pkg::idx_width(WIDTH);

    logic [WIDTH-1:0] mask_i;
    logic             mask_val;
    logic             mask_rdy;
    logic [IDX_W-1:0] idx_o;
    logic             idx_val;
    logic             idx_rdy;
    logic             idx_last;
    logic             idx_empty;

    modport master (
        output mask_i, mask_val, idx_rdy,
        input  mask_rdy, idx_o, idx_val, idx_last, idx_empty
    );

    modport slave (
        input  mask_i, mask_val, idx_rdy,
        output mask_rdy, idx_o, idx_val, idx_last, idx_empty
    );

endinterface

// File: rtl/mask_index_encoder_prio_enc_msb.sv
// Combinational priority encoder: index of the highest set bit (MSB = index 0),
// plus any-bit and exactly-one-bit flags.
module mask_index_encoder_prio_enc_msb #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    // Ascending scan so the highest set bit is the last assignment to win.
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int pos = 0; pos < WIDTH; pos++) begin
            if (vec[pos]) idx = IDX_W'(WIDTH - 1 - pos);
        end
    end

    assign any    = |vec;
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mask_index_encoder.sv
// Sequential sparse-mask encoder: emits the MSB-first index of every set bit of a
// mask, one beat per cycle; an all-zero mask produces a single empty beat.
module mask_index_encoder
    import mask_index_encoder_pkg::*;
#(
    parameter int WIDTH = MASK_W
) (
    input logic                  clk,
    input logic                  rst_n,
    mask_index_encoder_if.slave  bus
);

    localparam int               IDX_W   = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] rem;
    logic             empty_r;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic [WIDTH-1:0] clr_bit;
    logic             busy;
    logic             last_fire;

    mask_index_encoder_prio_enc_msb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec    (rem),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    assign busy          = (state == ST_BUSY);
    assign bus.idx_val   = busy;
    assign bus.idx_o     = (busy && enc_any) ? enc_idx : '0;
    assign bus.idx_last  = busy && (enc_single || empty_r);
    assign bus.idx_empty = busy && empty_r;

    assign last_fire    = bus.idx_val && bus.idx_last && bus.idx_rdy;
    // Combinational from idx_rdy so the next mask loads on the final-beat edge.
    assign bus.mask_rdy = rst_n && ((state == ST_IDLE) || last_fire);

    assign clr_bit = WIDTH'(1) << (MAX_IDX - enc_idx);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: rem is a plain register (not a memory), so resetting it is cheap and keeps outputs X-free.
        if (!rst_n) begin
            state   <= ST_IDLE;
            rem     <= '0;
            empty_r <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (bus.mask_val) begin
                state   <= ST_BUSY;
                rem     <= bus.mask_i;
                empty_r <= (bus.mask_i == '0);
            end
        end else if (bus.idx_rdy) begin
            if (bus.idx_last) begin
                if (bus.mask_val) begin
                    rem     <= bus.mask_i;
                    empty_r <= (bus.mask_i == '0);
                end else begin
                    state   <= ST_IDLE;
                    rem     <= '0;
                    empty_r <= 1'b0;
                end
            end else begin
                rem <= rem & ~clr_bit;
            end
        end
    end

endmodule

// File: tb/tb_mask_index_encoder.sv
// Scoreboard bench for mask_index_encoder: a driver pushes expected beats derived from
// each accepted mask, a negedge monitor pops and compares every fired beat.
module tb_mask_index_encoder;

    typedef struct {
        logic [3:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    logic clk;
    logic rst_n;

    mask_index_encoder_if #(.WIDTH(16)) bus ();

    mask_index_encoder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    logic [15:0] mask_q[$];
    logic [15:0] acc_or;
    logic        pend_v;
    logic [15:0] pend_m;
    int          rdy_mode;
    logic        tog;

    // Reference: one beat per set bit in MSB-first order, or one empty beat for zero.
    task automatic push_beats(input logic [15:0] m);
        beat_t b;
        int    n;
        mask_q.push_back(m);
        if (m == 16'h0) begin
            b.idx = 4'd0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            n = $countones(m);
            for (int i = 0; i < 16; i++) begin
                if (m[15 - i]) begin
                    n--;
                    b.idx = 4'(i); b.last = (n == 0); b.empty = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    function automatic logic pick_rdy();
        case (rdy_mode)
            0:       return 1'b1;
            1:       begin tog = ~tog; return tog; end
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic cycle(input logic mv, input logic [15:0] m, output logic accepted);
        logic exp_rdy;
        @(posedge clk);
        if (pend_v) begin
            push_beats(pend_m);
            pend_v = 1'b0;
        end
        #1;
        bus.mask_val = mv;
        bus.mask_i   = m;
        bus.idx_rdy  = pick_rdy();
        #1;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.idx_rdy);
        checks++;
        if (bus.mask_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL mask_rdy: got %b expected %b at %0t", bus.mask_rdy, exp_rdy, $time);
        end
        accepted = mv && bus.mask_rdy;
        if (accepted) begin
            pend_v = 1'b1;
            pend_m = m;
        end
    endtask

    task automatic send(input logic [15:0] m);
        logic a;
        int   budget;
        a = 1'b0;
        budget = 200;
        while (!a && budget > 0) begin
            cycle(1'b1, m, a);
            budget--;
        end
        if (!a) begin
            failures++;
            $display("FAIL send_timeout: mask %h not accepted within 200 cycles", m);
        end
    endtask

    task automatic drain();
        logic a;
        int   budget;
        budget = 200;
        while ((exp_q.size() != 0 || pend_v) && budget > 0) begin
            cycle(1'b0, 16'($urandom), a);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0 || pend_v) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
            exp_q.delete();
            mask_q.delete();
            pend_v = 1'b0;
            acc_or = '0;
        end
    endtask

    function automatic logic [15:0] rand_mask();
        logic [15:0] r;
        case ($urandom_range(0, 7))
            0:       r = 16'h0;
            1:       r = 16'h8000 >> $urandom_range(0, 15);
            2, 3:    r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    // Monitor: decoupled from stimulus; compares each beat at the edge where it fires.
    always @(negedge clk) begin
        beat_t       e;
        logic [15:0] m;
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.idx_val !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL idx_val: got %b expected %b at %0t", bus.idx_val, exp_q.size() != 0, $time);
            end else if (!bus.idx_val) begin
                checks++;
                if ({bus.idx_o, bus.idx_last, bus.idx_empty} !== 6'b0) begin
                    failures++;
                    $display("FAIL idle_outputs: got idx=%h last=%b empty=%b expected all zero",
                             bus.idx_o, bus.idx_last, bus.idx_empty);
                end
            end else if (bus.idx_rdy) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.idx_o !== e.idx || bus.idx_last !== e.last || bus.idx_empty !== e.empty) begin
                    failures++;
                    $display("FAIL beat: got idx=%0d last=%b empty=%b expected idx=%0d last=%b empty=%b at %0t",
                             bus.idx_o, bus.idx_last, bus.idx_empty, e.idx, e.last, e.empty, $time);
                end
                if (!e.empty) acc_or = acc_or | (16'h8000 >> bus.idx_o);
                if (e.last) begin
                    m = mask_q.pop_front();
                    checks++;
                    if (acc_or !== m) begin
                        failures++;
                        $display("FAIL round_trip: decoded %h expected %h", acc_or, m);
                    end
                    acc_or = '0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.mask_val = 1'b1;
        bus.mask_i   = 16'hFFFF;
        bus.idx_rdy  = 1'b1;
        acc_or       = '0;
        pend_v       = 1'b0;
        pend_m       = '0;
        rdy_mode     = 0;
        tog          = 1'b0;

        // Reset held 3 cycles with mask_val asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (bus.mask_rdy !== 1'b0 || bus.idx_val !== 1'b0 || bus.idx_o !== 4'd0) begin
                failures++;
                $display("FAIL reset_state: got mask_rdy=%b idx_val=%b idx_o=%h expected 0 0 0",
                         bus.mask_rdy, bus.idx_val, bus.idx_o);
            end
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.mask_val = 1'b0;
        #1;
        checks++;
        if (bus.mask_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got mask_rdy=%b expected 1", bus.mask_rdy);
        end

        rdy_mode = 0;
        send(16'h8001); drain();
        send(16'h0000); drain();
        send(16'hFFFF); drain();

        rdy_mode = 1;
        tog      = 1'b0;
        send(16'h0420); drain();

        rdy_mode = 0;
        send(16'h0100); send(16'h0002); drain();

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            send(rand_mask());
            if ($urandom_range(0, 9) == 0) drain();
            if (i == 500) begin
                logic a;
                repeat ($urandom_range(1, 3)) cycle(1'b0, 16'h0, a);
                @(posedge clk);
                #1;
                rst_n        = 1'b0;
                bus.mask_val = 1'b0;
                exp_q.delete();
                mask_q.delete();
                pend_v       = 1'b0;
                acc_or       = '0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                #1;
                checks++;
                if (bus.idx_val !== 1'b0 || bus.mask_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_reset: got idx_val=%b mask_rdy=%b expected 0 1",
                             bus.idx_val, bus.mask_rdy);
                end
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
